matrix_multiply_pipe: RTL

//  Runtime-sized C[MxP] = A[MxN] * B[NxP] engine. Sizes run up to SIZE_COUNT in each dimension.
//  Row-oriented: SIZE_COUNT signed MAC lanes, one per column of C. Each cycle:
//  - reads one A row and one B row;
//  - broadcasts A[i][k] to every lane.

---
 rtl/matrix_multiply_pipe.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_multiply_pipe.sv
// Runtime-sized C = A * B engine: one signed MAC lane per C column, A element broadcast to all lanes.
// Optional SATURATE_EN: clamp C on narrowing instead of two's-complement wrap.
module matrix_multiply_pipe #(
    parameter int SIZE_COUNT = 8,
    parameter int SIZE_WIDTH = $clog2(SIZE_COUNT) + 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(SIZE_COUNT),
    parameter int FRAC_BITS  = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [SIZE_WIDTH-1:0]            mat_a_rows,
    input  logic [SIZE_WIDTH-1:0]            mat_a_cols,
    input  logic [SIZE_WIDTH-1:0]            mat_b_cols,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             mat_a_read,
    output logic [ADDR_WIDTH-1:0]            mat_a_address,
    input  logic [SIZE_COUNT*DATA_WIDTH-1:0] mat_a_read_data,
    output logic                             mat_b_read,
    output logic [ADDR_WIDTH-1:0]            mat_b_address,
    input  logic [SIZE_COUNT*DATA_WIDTH-1:0] mat_b_read_data,
    output logic                             mat_c_write,
    input  logic                             mat_c_ready,
    output logic [ADDR_WIDTH-1:0]            mat_c_address,
    output logic [SIZE_COUNT*DATA_WIDTH-1:0] mat_c_write_data,
    output logic [SIZE_COUNT-1:0]            mat_c_write_mask
);

    localparam int PW  = 2*DATA_WIDTH;
    localparam int DCW = $clog2(RD_LATENCY) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

    function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] acc);
`ifdef SATURATE_EN
        logic signed [ACC_WIDTH-1:0] s;
        logic signed [ACC_WIDTH-1:0] sat_max;
        logic signed [ACC_WIDTH-1:0] sat_min;
        sat_max = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        sat_min = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        s = acc >>> FRAC_BITS;
        if (s > sat_max)      narrow = sat_max[DATA_WIDTH-1:0];
        else if (s < sat_min) narrow = sat_min[DATA_WIDTH-1:0];
        else                  narrow = s[DATA_WIDTH-1:0];
`else
        narrow = DATA_WIDTH'(acc >>> FRAC_BITS);
`endif
    endfunction

    state_t                          state_q;
    logic [SIZE_WIDTH-1:0]           m_q, n_q, p_q, i_q, k_q;
    logic [DCW-1:0]                  drain_q;
    logic                            error_q;
    logic [RD_LATENCY-1:0]           vld_p;
    logic [SIZE_WIDTH-1:0]           tag_p [RD_LATENCY];
    logic signed [ACC_WIDTH-1:0]     acc_q [SIZE_COUNT];
    logic signed [ACC_WIDTH-1:0]     acc_d [SIZE_COUNT];
    logic signed [DATA_WIDTH-1:0]    a_elem;
    logic signed [DATA_WIDTH-1:0]    b_lane [SIZE_COUNT];
    logic signed [PW-1:0]            prod [SIZE_COUNT];
    logic [SIZE_COUNT*DATA_WIDTH-1:0] c_data_q;
    logic [SIZE_COUNT-1:0]           mask_q;
    logic                            size_bad;

    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign error            = error_q;
    assign mat_a_read       = (state_q == S_ISSUE);
    assign mat_b_read       = (state_q == S_ISSUE);
    assign mat_a_address    = ADDR_WIDTH'(i_q);
    assign mat_b_address    = ADDR_WIDTH'(k_q);
    assign mat_c_write      = (state_q == S_WRITE);
    assign mat_c_address    = ADDR_WIDTH'(i_q);
    assign mat_c_write_data = c_data_q;
    assign mat_c_write_mask = mask_q;

    assign size_bad = (mat_a_rows == '0) || (mat_a_rows > SIZE_WIDTH'(SIZE_COUNT)) ||
                      (mat_a_cols == '0) || (mat_a_cols > SIZE_WIDTH'(SIZE_COUNT)) ||
                      (mat_b_cols == '0) || (mat_b_cols > SIZE_WIDTH'(SIZE_COUNT));

    // Read-return stage: the tagged A element is broadcast and every lane accumulates.
    always_comb begin
        a_elem = '0;
        for (int j = 0; j < SIZE_COUNT; j++) begin
            if (tag_p[RD_LATENCY-1] == SIZE_WIDTH'(j))
                a_elem = mat_a_read_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int j = 0; j < SIZE_COUNT; j++) begin
            b_lane[j] = mat_b_read_data[j*DATA_WIDTH +: DATA_WIDTH];
            prod[j]   = PW'(a_elem) * PW'(b_lane[j]);
            acc_d[j]  = acc_q[j];
            if (vld_p[RD_LATENCY-1])
                acc_d[j] = acc_q[j] + ACC_WIDTH'(prod[j]);
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= k_q;
        for (int s = 1; s < RD_LATENCY; s++)
            tag_p[s] <= tag_p[s-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            i_q      <= '0;
            k_q      <= '0;
            drain_q  <= '0;
            error_q  <= 1'b0;
            vld_p    <= '0;
            c_data_q <= '0;
            mask_q   <= '0;
            for (int j = 0; j < SIZE_COUNT; j++)
                acc_q[j] <= '0;
        end else begin
            error_q  <= 1'b0;
            vld_p[0] <= (state_q == S_ISSUE);
            for (int s = 1; s < RD_LATENCY; s++)
                vld_p[s] <= vld_p[s-1];
            for (int j = 0; j < SIZE_COUNT; j++)
                acc_q[j] <= acc_d[j];
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q <= mat_a_rows;
                        n_q <= mat_a_cols;
                        p_q <= mat_b_cols;
                        if (size_bad) begin
                            error_q <= 1'b1;
                        end else begin
                            i_q     <= '0;
                            k_q     <= '0;
                            state_q <= S_ISSUE;
                            for (int j = 0; j < SIZE_COUNT; j++)
                                acc_q[j] <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (k_q == n_q - SIZE_WIDTH'(1)) begin
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        k_q <= k_q + SIZE_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // acc_d already includes the final product returning this cycle.
                    if (drain_q == DCW'(RD_LATENCY - 1)) begin
                        for (int j = 0; j < SIZE_COUNT; j++) begin
                            c_data_q[j*DATA_WIDTH +: DATA_WIDTH] <=
                                (SIZE_WIDTH'(j) < p_q) ? narrow(acc_d[j]) : '0;
                            mask_q[j] <= (SIZE_WIDTH'(j) < p_q);
                        end
                        state_q <= S_WRITE;
                    end else begin
                        drain_q <= drain_q + DCW'(1);
                    end
                end
                S_WRITE: begin
                    if (mat_c_ready) begin
                        if (i_q == m_q - SIZE_WIDTH'(1)) begin
                            state_q <= S_DONE;
                        end else begin
                            i_q     <= i_q + SIZE_WIDTH'(1);
                            k_q     <= '0;
                            state_q <= S_ISSUE;
                            for (int j = 0; j < SIZE_COUNT; j++)
                                acc_q[j] <= '0;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
